hilo_muldiv_iter: RTL
=====================

// Module: hilo_muldiv_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage; replaces the separate mul/div pair.
//  Serves MULT/MULTU/DIV/DIVU and returns a {hi, lo} pair for HI/LO write-back.
//  Drives the EX stall request and honours pipeline flush mid-operation.
//  Adds to the previous generation: configurable width, configurable multiply bits-per-cycle, and a fixed divide-by-zero result.
// PARAMETERS
//  WIDTH     32  operand width; hi_o and lo_o are WIDTH each; must be even and >= 8
//  MUL_STEP  1   multiplier bits retired per CALC cycle; must be 1, 2 or 4 and divide WIDTH
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  resetn     in   1      synchronous, active-low reset
//  flush      in   1      abort the current operation; has priority over start
//  start_i    in   1      request; sampled only in IDLE; held high by EX until stallreq_o falls
//  op_i       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  opa_i      in   WIDTH  multiplicand / dividend; sampled with start
//  opb_i      in   WIDTH  multiplier / divisor; sampled with start
//  stallreq_o out  1      (IDLE & start_i & ~flush) | state in {PREP, CALC, FIX}
//  busy_o     out  1      state != IDLE
//  ready_o    out  1      one-cycle pulse in DONE; hi_o/lo_o valid
//  hi_o       out  WIDTH  product[2W-1:W] or remainder; held until the next DONE
//  lo_o       out  WIDTH  product[W-1:0] or quotient; held until the next DONE
// BEHAVIOUR
//  - Reset (resetn=0 at an edge): state IDLE, counter 0, all outputs 0. An operation in progress is dropped.
//  - FSM: IDLE -start&~flush-> PREP -> CALC -> FIX -> DONE -> IDLE.
//  - IDLE without start stays IDLE. DONE always returns to IDLE; start_i in DONE is ignored (no re-issue).
//  - PREP: latch sign flags; take magnitudes for signed ops, raw values for unsigned ops; load counter.
//  - CALC: DIV runs radix-2 restoring division, 1 bit/cycle, WIDTH cycles. MUL runs shift-add, MUL_STEP bits/cycle, WIDTH/MUL_STEP cycles.
//  - Counter counts down; leave CALC when it reaches 0.
//  - FIX: conditional two's-complement negation.
//  - Signed product negated when sign(a)^sign(b).
//  - Quotient negated when sign(a)^sign(b); remainder takes sign(a).
//  - Latency: start accepted at edge t0; ready_o high in cycle t0+CALC+3.
//  - Default latency is WIDTH+3 cycles for DIV and WIDTH/MUL_STEP+3 cycles for MUL.
//  - stallreq_o is 0 in DONE, so EX advances on the same edge that ready_o is seen.
//  - Divide by zero (opb=0, any signedness): hi_o = opa, lo_o = all ones. Sign fix is skipped.
//  - Signed overflow MIN/-1: lo_o = MIN, hi_o = 0 (natural wrap). No flag.
//  - flush in any state: next state IDLE; no ready_o; hi_o/lo_o unchanged.
//  - flush and start together in IDLE: start is ignored.
//  - Arithmetic uses a WIDTH+1 bit partial remainder and a 2*WIDTH product register. No truncation until output.
// CONFIGURATION
//  `MULDIV_EARLY_OUT_EN defined:
//   - DIV with opb=0 or |a|<|b| skips CALC (PREP->FIX). Quotient is 0 and remainder is a, or the div-by-zero result.
//   - MUL with either operand 0 skips CALC; product is 0.
//   - Early-out latency is 3 cycles.
//  Undefined: CALC always runs its full cycle count, giving deterministic latency.
//  Results are identical either way.
// STRUCTURE
//  - defines.vh holds: op codes MULDIV_OP_MULT/MULTU/DIV/DIVU; state codes IDLE/PREP/CALC/FIX/DONE (3-bit); counter width $clog2(WIDTH)+1 as a localparam.
//  - One natural sub-module: div_restore_step, a combinational single radix-2 step.
//  - div_restore_step takes {rem, quo, divisor} and returns next {rem, quo}.
//  - The multiply datapath stays inline.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF, WIDTH=32, MUL_STEP=1 -> ready_o at t0+35; hi=0xFFFFFFFE, lo=0x00000001.
//  2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  3. DIVU 5/0 and DIV -5/0 -> hi=opa_i, lo=0xFFFFFFFF.
//  3a. Repeat case 3 with `MULDIV_EARLY_OUT_EN -> ready_o at t0+3.
//  4. flush at CALC cycle 10 of a DIV -> IDLE next cycle; no ready_o; hi/lo keep the prior result.
//  4a. New start 1 cycle later completes normally.
//  5. resetn=0 during CALC -> all outputs 0 next cycle.
//  5a. start_i held high through DONE -> exactly one ready_o; busy_o falls; no second operation.
//  6. WIDTH=16, MUL_STEP=4, MULT -3*5 -> ready_o at t0+7; {hi,lo}=0xFFFF_FFF1.

Source files
------------

// File: rtl/hilo_muldiv_iter_pkg.sv
// hilo_muldiv_iter_pkg
//   Shared definitions for the iterative HI/LO multiply/divide unit.
//   Provides the op encodings, the FSM state encoding and the counter
//   width helper used by every file in this slice.
package hilo_muldiv_iter_pkg;

    typedef enum logic [1:0] {
        MULDIV_OP_MULT  = 2'b00,
        MULDIV_OP_MULTU = 2'b01,
        MULDIV_OP_DIV   = 2'b10,
        MULDIV_OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

    // Counter must hold WIDTH itself, hence the extra bit.
    function automatic int muldiv_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/hilo_muldiv_iter_if.sv
// hilo_muldiv_iter_if
//   Request/response bundle between the EX stage (master) and the
//   multiply/divide unit (slave).
//   master drives : flush, start_i, op_i, opa_i, opb_i
//   slave drives  : stallreq_o, busy_o, ready_o, hi_o, lo_o
interface hilo_muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] opa_i;
    logic [WIDTH-1:0] opb_i;
    logic             stallreq_o;
    logic             busy_o;
    logic             ready_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flush, start_i, op_i, opa_i, opb_i,
        input  stallreq_o, busy_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  flush, start_i, op_i, opa_i, opb_i,
        output stallreq_o, busy_o, ready_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_iter_div_restore_step.sv
// div_restore_step
//   One combinational radix-2 restoring-division step.
//   i_rem : partial remainder (WIDTH+1 bits)
//   i_quo : dividend bits still to shift in / quotient bits already formed
//   i_div : divisor magnitude
//   o_rem : next partial remainder
//   o_quo : next quotient/dividend register
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    // Bring the next dividend bit into the remainder, try the subtraction.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, i_div};

    // Negative trial result: restore (keep the shifted value), quotient bit 0.
    assign o_rem = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
endmodule

// File: rtl/hilo_muldiv_iter.sv
// hilo_muldiv_iter
//   Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, returning {hi, lo}
//   for HI/LO write-back. Raises the EX stall request while working and
//   drops the operation on flush.
//   Ports: clk, resetn (synchronous, active-low), bus (slave modport of
//   hilo_muldiv_iter_if: flush, start_i, op_i, opa_i, opb_i in;
//   stallreq_o, busy_o, ready_o, hi_o, lo_o out).
//   Build option: MULDIV_EARLY_OUT_EN skips CALC for trivially-known results
//   (divide by zero, |a|<|b|, multiply by zero); results are unchanged.
module hilo_muldiv_iter
    import hilo_muldiv_iter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             resetn,
    hilo_muldiv_iter_if.slave bus
);
    localparam int               CNT_W   = muldiv_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(WIDTH / MUL_STEP);

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2*WIDTH)'(1);
    endfunction

    muldiv_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opa, r_opb;
    logic               r_neg_main, r_neg_rem, r_bzero;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo, r_dvsr;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic                    w_is_div, w_signed, w_early;
    logic [WIDTH-1:0]        w_mag_a, w_mag_b;
    logic [WIDTH:0]          w_rem_nxt;
    logic [WIDTH-1:0]        w_quo_nxt;
    logic [WIDTH+MUL_STEP-1:0] w_pp, w_sum;
    logic [2*WIDTH-1:0]      w_prod_nxt, w_prod_fix;
    logic [WIDTH-1:0]        w_hi_fix, w_lo_fix;

    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_mag_a  = (w_signed && r_opa[WIDTH-1]) ? f_neg_w(r_opa) : r_opa;
    assign w_mag_b  = (w_signed && r_opb[WIDTH-1]) ? f_neg_w(r_opb) : r_opb;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = w_is_div ? ((w_mag_b == '0) || (w_mag_a < w_mag_b))
                              : ((r_opa == '0) || (r_opb == '0));
`else
    assign w_early = 1'b0;
`endif

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_dvsr),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // Shift-add: low MUL_STEP multiplier bits select a partial product that
    // is added into the upper half, then the whole register shifts right.
    assign w_pp       = {MUL_STEP'(0), r_mcand} * {WIDTH'(0), r_prod[MUL_STEP-1:0]};
    assign w_sum      = {MUL_STEP'(0), r_prod[2*WIDTH-1:WIDTH]} + w_pp;
    assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:MUL_STEP]};

    always_comb begin
        w_hi_fix   = '0;
        w_lo_fix   = '0;
        w_prod_fix = r_prod;
        if (w_is_div) begin
            if (r_bzero) begin
                // Divide by zero: fixed result, sign correction not applied.
                w_hi_fix = r_opa;
                w_lo_fix = '1;
            end else begin
                w_lo_fix = r_neg_main ? f_neg_w(r_quo) : r_quo;
                w_hi_fix = r_neg_rem  ? f_neg_w(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
            end
        end else begin
            w_prod_fix = r_neg_main ? f_neg_2w(r_prod) : r_prod;
            w_hi_fix   = w_prod_fix[2*WIDTH-1:WIDTH];
            w_lo_fix   = w_prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start_i) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = w_early ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_PREP: r_cnt <= w_is_div ? DIV_CYC : MUL_CYC;
                ST_CALC: r_cnt <= r_cnt - CNT_W'(1);
                ST_FIX: begin
                    // A flush in FIX must leave the previous result visible.
                    if (!bus.flush) begin
                        r_hi <= w_hi_fix;
                        r_lo <= w_lo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            ST_IDLE: begin
                r_op  <= bus.op_i;
                r_opa <= bus.opa_i;
                r_opb <= bus.opb_i;
            end
            ST_PREP: begin
                r_neg_main <= w_signed & (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]);
                r_neg_rem  <= w_signed & r_opa[WIDTH-1];
                r_bzero    <= (r_opb == '0);
                r_mcand    <= w_mag_a;
                r_dvsr     <= w_mag_b;
                if (w_early) begin
                    r_prod <= '0;
                    r_quo  <= '0;
                    r_rem  <= {1'b0, w_mag_a};
                end else begin
                    r_prod <= {WIDTH'(0), w_mag_b};
                    r_quo  <= w_mag_a;
                    r_rem  <= '0;
                end
            end
            ST_CALC: begin
                if (w_is_div) begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                end else begin
                    r_prod <= w_prod_nxt;
                end
            end
            default: ;
        endcase
    end

    assign bus.stallreq_o = ((r_state == ST_IDLE) && bus.start_i && !bus.flush)
                          || (r_state == ST_PREP) || (r_state == ST_CALC)
                          || (r_state == ST_FIX);
    assign bus.busy_o     = (r_state != ST_IDLE);
    assign bus.ready_o    = (r_state == ST_DONE);
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;
endmodule
